reg_serializer: RTL

REG_SERIALIZER -- requirements
Module: reg_serializer

---
 rtl/reg_serializer.sv | 102 ++++++++++
 1 files changed

// File: rtl/reg_serializer.sv
// Byte-to-serial transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Each bit is held for CLKS_PER_BIT cycles; tx is driven on the same edge as each state change.
module reg_serializer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx,
    output logic       done
);

    // state  | meaning
    // IDLE   | line high, ready for load
    // START  | start bit (0) on tx
    // DATA   | data bit r_shift[r_idx] on tx
    // PARITY | even-parity bit on tx
    // STOP   | stop bit (1) on tx
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int              CW     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   RELOAD = CW'(CLKS_PER_BIT - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          w_bit_end;

    assign w_bit_end = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= 8'h00;
            tx      <= 1'b1;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == IDLE) begin
                if (load && ready) begin
                    r_shift <= data;
                    r_cnt   <= RELOAD;
                    r_idx   <= '0;
                    tx      <= 1'b0;
                    ready   <= 1'b0;
                    r_state <= START;
                end
            end else if (!w_bit_end) begin
                r_cnt <= r_cnt - CW'(1);
            end else begin
                // Bit period expired: reload the timer and present the next bit now.
                r_cnt <= RELOAD;
                case (r_state)
                    START: begin
                        r_state <= DATA;
                        r_idx   <= '0;
                        tx      <= r_shift[0];
                    end
                    DATA: begin
                        if (r_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                r_state <= PARITY;
                                tx      <= ^r_shift;
                            end else begin
                                r_state <= STOP;
                                tx      <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            tx    <= r_shift[r_idx + 3'd1];
                        end
                    end
                    PARITY: begin
                        r_state <= STOP;
                        tx      <= 1'b1;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        tx      <= 1'b1;
                        ready   <= 1'b1;
                        done    <= 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        tx      <= 1'b1;
                        ready   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
